// File: rtl/writeback_queue.sv
// writeback_queue: buffered write-back FIFO in front of the register file
// write port, with two youngest-entry forwarding lookups.
module writeback_queue #(
  parameter int WORD_LENGTH = 32,
  parameter int NBITS       = 5,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [NBITS-1:0]         In_Reg,
  input  logic [WORD_LENGTH-1:0]   In_Data,
  input  logic                     Hold,
  output logic                     Wr_En,
  output logic [NBITS-1:0]         Wr_Reg,
  output logic [WORD_LENGTH-1:0]   Wr_Data,
  input  logic [NBITS-1:0]         Fwd_Reg1,
  input  logic [NBITS-1:0]         Fwd_Reg2,
  output logic                     Fwd_Hit1,
  output logic                     Fwd_Hit2,
  output logic [WORD_LENGTH-1:0]   Fwd_Data1,
  output logic [WORD_LENGTH-1:0]   Fwd_Data2,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NBITS-1:0]       reg_q [DEPTH];
  logic [WORD_LENGTH-1:0] dat_q [DEPTH];
  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [CW-1:0]          cnt;

  logic accept;
  logic enq;
  logic deq;

  assign Empty    = (cnt == '0);
  assign Full     = (cnt == CW'(DEPTH));
  assign In_Ready = reset && !Full;
  assign accept   = In_Valid && In_Ready;
  // Writes to x0 are consumed but never occupy an entry.
  assign enq      = accept && (In_Reg != '0);
  assign deq      = !Empty && !Hold;
  assign Wr_En    = deq;
  assign Wr_Reg   = Empty ? '0 : reg_q[head];
  assign Wr_Data  = Empty ? '0 : dat_q[head];
  assign Count    = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        reg_q[tail] <= In_Reg;
        dat_q[tail] <= In_Data;
        tail        <= tail + AW'(1);
      end
      if (deq) begin
        head <= head + AW'(1);
      end
      if (enq && !deq) begin
        cnt <= cnt + CW'(1);
      end else if (!enq && deq) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Walk oldest to youngest so the last match wins.
  function automatic logic [WORD_LENGTH:0] lookup(
    input logic [NBITS-1:0] r
  );
    logic [WORD_LENGTH:0] res;
    logic [AW-1:0]        idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < cnt) && (r != '0) &&
          (reg_q[idx] == r)) begin
        res = {1'b1, dat_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {Fwd_Hit1, Fwd_Data1} = lookup(Fwd_Reg1);
    {Fwd_Hit2, Fwd_Data2} = lookup(Fwd_Reg2);
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_writeback_queue;

  localparam int W = 32;
  localparam int N = 5;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         In_Valid = 1'b0;
  logic         In_Ready;
  logic [N-1:0] In_Reg = '0;
  logic [W-1:0] In_Data = '0;
  logic         Hold = 1'b0;
  logic         Wr_En;
  logic [N-1:0] Wr_Reg;
  logic [W-1:0] Wr_Data;
  logic [N-1:0] Fwd_Reg1 = '0;
  logic [N-1:0] Fwd_Reg2 = '0;
  logic         Fwd_Hit1;
  logic         Fwd_Hit2;
  logic [W-1:0] Fwd_Data1;
  logic [W-1:0] Fwd_Data2;
  logic [2:0]   Count;
  logic         Full;
  logic         Empty;

  writeback_queue #(
    .WORD_LENGTH(W),
    .NBITS(N),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .In_Reg(In_Reg),
    .In_Data(In_Data),
    .Hold(Hold),
    .Wr_En(Wr_En),
    .Wr_Reg(Wr_Reg),
    .Wr_Data(Wr_Data),
    .Fwd_Reg1(Fwd_Reg1),
    .Fwd_Reg2(Fwd_Reg2),
    .Fwd_Hit1(Fwd_Hit1),
    .Fwd_Hit2(Fwd_Hit2),
    .Fwd_Data1(Fwd_Data1),
    .Fwd_Data2(Fwd_Data2),
    .Count(Count),
    .Full(Full),
    .Empty(Empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] r;
    logic [W-1:0] d;
  } ent_t;

  ent_t mq[$];
  ent_t olog[$];
  ent_t pushed[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [W:0] mfwd(input logic [N-1:0] r);
    if (r == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r == r) return {1'b1, mq[i].d};
    return '0;
  endfunction

  task automatic check_state();
    int c;
    logic [W:0] f1;
    logic [W:0] f2;
    c  = mq.size();
    f1 = mfwd(Fwd_Reg1);
    f2 = mfwd(Fwd_Reg2);
    check("count", 64'(Count), 64'(c));
    check("empty", 64'(Empty), 64'(c == 0));
    check("full", 64'(Full), 64'(c == D));
    check("in_ready", 64'(In_Ready), 64'(reset && c < D));
    check("wr_en", 64'(Wr_En), 64'(c != 0 && !Hold));
    check("wr_reg", 64'(Wr_Reg), 64'(c != 0 ? mq[0].r : '0));
    check("wr_data", 64'(Wr_Data), 64'(c != 0 ? mq[0].d : '0));
    check("fwd1", 64'({Fwd_Hit1, Fwd_Data1}), 64'(f1));
    check("fwd2", 64'({Fwd_Hit2, Fwd_Data2}), 64'(f2));
  endtask

  // One clock: drive, check against model, take edge, update model.
  task automatic cycle(input logic v, input logic [N-1:0] r,
                       input logic [W-1:0] d, input logic h,
                       input logic [N-1:0] f1,
                       input logic [N-1:0] f2);
    logic acc;
    logic drn;
    In_Valid = v;
    In_Reg   = r;
    In_Data  = d;
    Hold     = h;
    Fwd_Reg1 = f1;
    Fwd_Reg2 = f2;
    #1;
    check_state();
    acc = v && reset && (mq.size() < D);
    drn = (mq.size() != 0) && !h;
    if (Wr_En) olog.push_back('{Wr_Reg, Wr_Data});
    @(posedge clk);
    if (drn) void'(mq.pop_front());
    if (acc && r != '0) begin
      mq.push_back('{r, d});
      pushed.push_back('{r, d});
    end
    #1;
  endtask

  task automatic idle(input logic h);
    cycle(1'b0, '0, '0, h, '0, '0);
  endtask

  initial begin
    logic [W-1:0] exp_d;
    // reset state
    #12;
    check_state();
    check("rst_ready", 64'(In_Ready), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 64'(In_Ready), 64'(1));

    // single write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, '0);
    check("t1_wr_en", 64'(Wr_En), 64'(1));
    check("t1_wr_reg", 64'(Wr_Reg), 64'(5));
    check("t1_wr_data", 64'(Wr_Data), 64'hDEADBEEF);
    check("t1_fwd", 64'(Fwd_Hit1), 64'(1));
    idle(1'b0);
    check("t1_empty", 64'(Empty), 64'(1));

    // async reset with 3 entries queued
    for (int i = 0; i < 3; i++)
      cycle(1'b1, N'(9 + i), W'(i + 1), 1'b1, '0, '0);
    check("t1b_cnt3", 64'(Count), 64'(3));
    In_Valid = 1'b0;
    Hold = 1'b0;
    reset = 1'b0;
    #1;
    mq.delete();
    check("t1b_cnt0", 64'(Count), 64'(0));
    check("t1b_wr_en", 64'(Wr_En), 64'(0));
    check("t1b_ready", 64'(In_Ready), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // fill with Hold, fifth stays pending, then drain in order
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, N'(i), W'(i * 32'h11), 1'b1, '0, '0);
    check("t2_full", 64'(Full), 64'(1));
    check("t2_cnt", 64'(Count), 64'(4));
    check("t2_ready", 64'(In_Ready), 64'(0));
    cycle(1'b1, 5'd6, 32'h55, 1'b1, '0, '0);
    check("t2_pend", 64'(Count), 64'(4));
    olog.delete();
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("t2_nlog", 64'(olog.size()), 64'(4));
    for (int i = 0; i < 4 && i < olog.size(); i++) begin
      check("t2_reg", 64'(olog[i].r), 64'(i + 1));
      check("t2_dat", 64'(olog[i].d), 64'((i + 1) * 'h11));
    end

    // forwarding returns youngest
    cycle(1'b1, 5'd7, 32'hA, 1'b1, '0, '0);
    cycle(1'b1, 5'd7, 32'hB, 1'b1, '0, '0);
    In_Valid = 1'b0;
    Fwd_Reg1 = 5'd7;
    Fwd_Reg2 = 5'd8;
    #1;
    check("t3_hit1", 64'(Fwd_Hit1), 64'(1));
    check("t3_dat1", 64'(Fwd_Data1), 64'hB);
    check("t3_hit2", 64'(Fwd_Hit2), 64'(0));
    check("t3_dat2", 64'(Fwd_Data2), 64'(0));
    idle(1'b0);
    idle(1'b0);

    // register 0 discarded
    cycle(1'b1, '0, 32'hFFFF, 1'b0, '0, '0);
    check("t4_cnt", 64'(Count), 64'(0));
    check("t4_wr_en", 64'(Wr_En), 64'(0));
    check("t4_hit", 64'(Fwd_Hit1), 64'(0));

    // push/pop at Count=2 over 10 cycles
    pushed.delete();
    olog.delete();
    cycle(1'b1, 5'd12, 32'h100, 1'b1, '0, '0);
    cycle(1'b1, 5'd13, 32'h101, 1'b1, '0, '0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, N'(14 + i), W'(32'h102 + i), 1'b0, '0, '0);
      check("t5_cnt", 64'(Count), 64'(2));
    end
    idle(1'b0);
    idle(1'b0);
    check("t5_nlog", 64'(olog.size()), 64'(12));
    for (int i = 0; i < 12 && i < olog.size(); i++) begin
      exp_d = W'(32'h100 + i);
      check("t5_seq", 64'(olog[i].d), 64'(exp_d));
    end

    // full with drain: no accept that cycle
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, N'(i), W'(i), 1'b1, '0, '0);
    cycle(1'b1, 5'd20, 32'h20, 1'b0, 5'd20, '0);
    check("t6_cnt3", 64'(Count), 64'(3));
    check("t6_nohit", 64'(Fwd_Hit1), 64'(0));
    cycle(1'b1, 5'd20, 32'h20, 1'b0, 5'd20, '0);
    check("t6_cnt_b", 64'(Count), 64'(3));
    check("t6_hit", 64'(Fwd_Hit1), 64'(1));
    for (int i = 0; i < 4; i++) idle(1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60,
            N'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 99) < 35,
            N'($urandom_range(0, 7)),
            N'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffered write-back stage that sits directly upstream of the register file's single write port. It accepts (register, data) write requests from the execute stage over a valid/ready handshake and holds them in a DEPTH-entry FIFO. It drains one entry per cycle into the register file's Write_Reg/Write_Data/Write inputs. Two forwarding lookups return the youngest pending value for a register, so readers never see stale register-file data while a write is still queued.

## Interface
- WORD_LENGTH, 32, data width; matches the register file word
- NBITS, 5, register address width
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- In_Valid  input  1  write request present
- In_Ready  output  1  queue can accept this cycle
- In_Reg  input  NBITS  destination register of request
- In_Data  input  WORD_LENGTH  data of request
- Hold  input  1  inhibits draining while high
- Wr_En  output  1  drives register-file Write
- Wr_Reg  output  NBITS  drives Write_Reg
- Wr_Data  output  WORD_LENGTH  drives Write_Data
- Fwd_Reg1, Fwd_Reg2  input  NBITS  lookup addresses; tie to Read_Reg1/Read_Reg2
- Fwd_Hit1, Fwd_Hit2  output  1  a pending entry matches
- Fwd_Data1, Fwd_Data2  output  WORD_LENGTH  youngest matching pending data
- Count  output  CeilLog2(DEPTH)+1  number of occupied entries
- Full, Empty  output  1  occupancy flags

## Operation
- State: DEPTH entries of {reg, data}, head pointer, tail pointer, and Count. Pointers wrap modulo DEPTH.
- Empty = (Count==0). Full = (Count==DEPTH).
- In_Ready = !Full while reset is high. In_Ready is forced to 0 while reset is low.
- Accept = In_Valid && In_Ready.
  - If In_Reg != 0, the entry is written at tail and tail increments.
  - If In_Reg == 0, the request is consumed and discarded; no entry is written and Count is unchanged.
- Drain: Wr_En = !Empty && !Hold, combinational from state.
  - Wr_Reg/Wr_Data = head entry when !Empty; otherwise both are 0.
  - On a clock edge with Wr_En high, head increments.
- Count update: +1 on enqueue only, -1 on drain only, unchanged when both or neither occur.
- Simultaneous enqueue and drain is legal at any non-full occupancy. When Full, In_Ready is 0, so no enqueue happens that cycle even if a drain occurs.
- Forwarding, per port: Fwd_Hit is high if any occupied entry has reg == Fwd_Reg and Fwd_Reg != 0.
  - Fwd_Data is the data of the youngest matching entry, searched from tail-1 back to head.
  - When there is no hit, Fwd_Data = 0.
  - An un-accepted incoming request is not visible to forwarding.
- Hold high freezes head. Enqueue continues until Full.
- Reset low: Count, head and tail go to 0, and all entries clear to 0. The queue is lost mid-operation; no partial writes are issued.

## Timing
- Reset values: In_Ready 0 during reset and 1 after release; Wr_En 0; Wr_Reg 0; Wr_Data 0; Fwd_Hit* 0; Fwd_Data* 0; Count 0; Full 0; Empty 1.
- Enqueue-to-write latency, empty queue and Hold low:
  - Request accepted at edge k.
  - Wr_En is high during cycle k→k+1.
  - The register file captures the write at edge k+1.
- Forwarding window: Fwd_Hit goes high in the cycle after acceptance. It stays high through the cycle in which that entry's Wr_En is asserted. From the following cycle the value is in the register file.
- Throughput: one accept and one drain per cycle sustained.
- All outputs are combinational from registered state. Fwd_* additionally depend combinationally on Fwd_Reg*. No output depends combinationally on In_Valid.

## Test plan
- Reset then single write: In_Reg=5, In_Data=0xDEADBEEF accepted at edge 1 -> Wr_En=1, Wr_Reg=5, Wr_Data=0xDEADBEEF in the next cycle; Empty=1 after edge 2. Assert reset low mid-stream with 3 entries queued -> Count=0 and Wr_En=0 immediately.
- Fill with Hold=1: push regs 1,2,3,4 with data 0x11..0x44 -> Full=1, Count=4, In_Ready=0; a fifth request stays pending. Release Hold -> writes drain in order 1,2,3,4, one per cycle.
- Forwarding youngest: with Hold=1 push reg 7 = 0xA, then reg 7 = 0xB; Fwd_Reg1=7 -> Fwd_Hit1=1, Fwd_Data1=0xB; Fwd_Reg2=8 -> Fwd_Hit2=0, Fwd_Data2=0.
- Register 0: push In_Reg=0, In_Data=0xFFFF -> In_Ready=1, Count stays 0, Wr_En never asserts; Fwd_Reg1=0 -> Fwd_Hit1=0.
- Simultaneous push/pop at Count=2 with Hold=0 -> Count stays 2; pointers wrap correctly over 10 continuous cycles; drained sequence equals pushed sequence.
- Full with drain: Count=4 and Hold released with In_Valid=1 -> no accept that cycle; Count=3; the request is accepted on the next edge.
